// File: rtl/gmii_tx_buffer.sv
// GMII TX rate adapter: buffers whole MAC frames and replays them as nibbles for 10/100, bypasses at 1000M.
// Optional statistics ports are enabled by defining GMII_TX_BUF_STATS_EN.
module gmii_tx_buffer #(
    parameter int DATA_DEPTH = 4096,
    parameter int LEN_DEPTH  = 16,
    parameter int IFG_CYCLES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        eth_100m_en,
    input  logic        eth_10m_en,
    input  logic        link,
    input  logic        mac_tx_dv,
    input  logic [7:0]  mac_txd,
`ifdef GMII_TX_BUF_STATS_EN
    output logic [15:0] tx_frame_cnt,
    output logic [15:0] tx_drop_cnt,
`endif
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        tx_overflow
);
    localparam int AW = $clog2(DATA_DEPTH);
    localparam int LW = $clog2(LEN_DEPTH);
    localparam int CW = $clog2(IFG_CYCLES + 1);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] FULL_USED = (AW+1)'(DATA_DEPTH);
    localparam logic [AW:0] MAX_LEN   = (AW+1)'(DATA_DEPTH - 1);
    localparam logic [LW:0] LEN_FULL  = (LW+1)'(LEN_DEPTH);
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PREF, S_SEND_LO, S_SEND_HI, S_IFG} state_t;

    logic buf_mode;
    assign buf_mode = eth_100m_en | eth_10m_en;

    logic [AW:0]   wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d, byte_cnt_q, byte_cnt_d;
    logic          dv_prev_q, bad_q, bad_d, ovf_d;
    logic          data_wr, len_push, len_pop, rd_en;
    logic          data_full, len_full, len_empty, frame_end;
    logic [LW:0]   len_cnt_q, len_cnt_d;
    logic [LW-1:0] len_wr_q, len_rd_q;
    logic [AW:0]   len_mem [LEN_DEPTH];
    logic [7:0]    data_mem [DATA_DEPTH];
    logic [7:0]    rd_data_q, cur_byte_q, cur_byte_d;
    logic [AW:0]   rem_len_q, rem_len_d;
    logic [CW-1:0] ifg_cnt_q, ifg_cnt_d;
    state_t        state_q, state_d;
    logic          tx_en_q, tx_en_d;
    logic [7:0]    txd_q, txd_d;

    assign data_full = (wr_ptr_q - rd_ptr_q) == FULL_USED;
    assign len_full  = len_cnt_q == LEN_FULL;
    assign len_empty = len_cnt_q == '0;
    assign frame_end = buf_mode & dv_prev_q & ~mac_tx_dv;

    // Bytes of a frame land beyond commit_ptr and only become visible once the length is pushed.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        byte_cnt_d   = byte_cnt_q;
        bad_d        = bad_q;
        data_wr      = 1'b0;
        len_push     = 1'b0;
        ovf_d        = 1'b0;
        if (buf_mode && mac_tx_dv) begin
            if (bad_q || data_full || byte_cnt_q == MAX_LEN) begin
                bad_d = 1'b1;
            end else begin
                data_wr    = 1'b1;
                wr_ptr_d   = wr_ptr_q + PTR_ONE;
                byte_cnt_d = byte_cnt_q + PTR_ONE;
            end
        end else if (frame_end) begin
            if (bad_q || len_full) begin
                wr_ptr_d = commit_ptr_q;
                ovf_d    = 1'b1;
            end else begin
                len_push     = 1'b1;
                commit_ptr_d = wr_ptr_q;
            end
            byte_cnt_d = '0;
            bad_d      = 1'b0;
        end
    end

    always_comb begin
        len_cnt_d = len_cnt_q;
        if (len_push && !len_pop) begin
            len_cnt_d = len_cnt_q + (LW+1)'(1);
        end else if (!len_push && len_pop) begin
            len_cnt_d = len_cnt_q - (LW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (data_wr) begin
            data_mem[wr_ptr_q[AW-1:0]] <= mac_txd;
        end
        if (rd_en) begin
            rd_data_q <= data_mem[rd_ptr_q[AW-1:0]];
        end
        if (len_push) begin
            len_mem[len_wr_q] <= byte_cnt_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_len_d  = rem_len_q;
        cur_byte_d = cur_byte_q;
        ifg_cnt_d  = ifg_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        rd_en      = 1'b0;
        len_pop    = 1'b0;
        tx_en_d    = 1'b0;
        txd_d      = '0;
        case (state_q)
            S_IDLE: begin
                if (!len_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                len_pop   = 1'b1;
                rem_len_d = len_mem[len_rd_q];
                rd_en     = 1'b1;
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                state_d   = S_PREF;
            end
            S_PREF: begin
                cur_byte_d = rd_data_q;
                state_d    = S_SEND_LO;
            end
            S_SEND_LO: begin
                tx_en_d = 1'b1;
                txd_d   = {4'b0, cur_byte_q[3:0]};
                if (rem_len_q > PTR_ONE) begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
                state_d = S_SEND_HI;
            end
            S_SEND_HI: begin
                tx_en_d   = 1'b1;
                txd_d     = {4'b0, cur_byte_q[7:4]};
                rem_len_d = rem_len_q - PTR_ONE;
                if (rem_len_q == PTR_ONE) begin
                    ifg_cnt_d = '0;
                    state_d   = S_IFG;
                end else begin
                    cur_byte_d = rd_data_q;
                    state_d    = S_SEND_LO;
                end
            end
            S_IFG: begin
                if (ifg_cnt_q == IFG_LAST) state_d = S_IDLE;
                else ifg_cnt_d = ifg_cnt_q + CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        // 1000M: straight through, the FIFOs stay empty so the FSM never leaves IDLE
        if (!buf_mode) begin
            tx_en_d = mac_tx_dv;
            txd_d   = mac_txd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0; commit_ptr_q <= '0; rd_ptr_q <= '0; byte_cnt_q <= '0;
            dv_prev_q <= 1'b0; bad_q <= 1'b0; len_cnt_q <= '0; len_wr_q <= '0; len_rd_q <= '0;
            state_q <= S_IDLE; rem_len_q <= '0; cur_byte_q <= '0; ifg_cnt_q <= '0;
            tx_en_q <= 1'b0; txd_q <= '0; tx_overflow <= 1'b0;
        end else if (!link) begin
            wr_ptr_q <= '0; commit_ptr_q <= '0; rd_ptr_q <= '0; byte_cnt_q <= '0;
            dv_prev_q <= 1'b0; bad_q <= 1'b0; len_cnt_q <= '0; len_wr_q <= '0; len_rd_q <= '0;
            state_q <= S_IDLE; rem_len_q <= '0; cur_byte_q <= '0; ifg_cnt_q <= '0;
            tx_en_q <= 1'b0; txd_q <= '0; tx_overflow <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            dv_prev_q    <= buf_mode & mac_tx_dv;
            bad_q        <= bad_d;
            len_cnt_q    <= len_cnt_d;
            if (len_push) len_wr_q <= len_wr_q + LW'(1);
            if (len_pop)  len_rd_q <= len_rd_q + LW'(1);
            state_q      <= state_d;
            rem_len_q    <= rem_len_d;
            cur_byte_q   <= cur_byte_d;
            ifg_cnt_q    <= ifg_cnt_d;
            tx_en_q      <= tx_en_d;
            txd_q        <= txd_d;
            tx_overflow  <= ovf_d;
        end
    end

    assign gmii_tx_en = tx_en_q;
    assign gmii_txd   = txd_q;

`ifdef GMII_TX_BUF_STATS_EN
    logic        frame_done;
    logic [15:0] frame_cnt_q, drop_cnt_q;
    assign frame_done = (state_q == S_SEND_HI) && (rem_len_q == PTR_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (!link) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (ovf_d)      drop_cnt_q  <= drop_cnt_q + 16'd1;
        end
    end

    assign tx_frame_cnt = frame_cnt_q;
    assign tx_drop_cnt  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_gmii_tx_buffer.sv
// Bench for gmii_tx_buffer: bypass vector table, directed 10/100 corner cases and a paced random run
// checked against a frame-level reference (queue of expected frames, nibble order low then high).
module tb_gmii_tx_buffer;
    localparam int DEPTH  = 128;
    localparam int LDEPTH = 16;
    localparam int IFG    = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       eth_100m_en = 1'b0;
    logic       eth_10m_en = 1'b0;
    logic       link = 1'b0;
    logic       mac_tx_dv = 1'b0;
    logic [7:0] mac_txd = 8'h00;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;
    logic       tx_overflow;
`ifdef GMII_TX_BUF_STATS_EN
    logic [15:0] tx_frame_cnt, tx_drop_cnt;
`endif

    always #5 clk = ~clk;

    gmii_tx_buffer #(.DATA_DEPTH(DEPTH), .LEN_DEPTH(LDEPTH), .IFG_CYCLES(IFG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .eth_100m_en (eth_100m_en),
        .eth_10m_en  (eth_10m_en),
        .link        (link),
        .mac_tx_dv   (mac_tx_dv),
        .mac_txd     (mac_txd),
`ifdef GMII_TX_BUF_STATS_EN
        .tx_frame_cnt(tx_frame_cnt),
        .tx_drop_cnt (tx_drop_cnt),
`endif
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .tx_overflow (tx_overflow)
    );

    typedef struct {
        logic       dv;
        logic [7:0] d;
        logic       exp_en;
        logic [7:0] exp_d;
    } vec_t;
    vec_t tbl[9];

    int checks = 0;
    int errors = 0;
    byte unsigned exp_bytes[$];
    int           exp_lens[$];
    byte unsigned frm[$];
    logic [3:0]   nib_q[$];
    logic [3:0]   lat_nib[8];
    bit mon_en = 1'b0;
    bit in_burst = 1'b0;
    int idle_cnt = 1000;
    int ovf_cnt = 0;
    int frames_out = 0;
    int bytes_out = 0;
    int burst_no = 0;
    int bytes_sent = 0;
    int frames_sent = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic end_burst();
        int n;
        bit ok;
        byte unsigned b;
        burst_no++;
        checks++;
        if (exp_lens.size() == 0) begin
            errors++;
            $display("FAIL burst_%0d: %0d nibbles replayed, required no burst", burst_no, nib_q.size());
            nib_q.delete();
            return;
        end
        n  = exp_lens.pop_front();
        ok = (nib_q.size() == 2 * n);
        for (int i = 0; i < n; i++) begin
            b = exp_bytes.pop_front();
            if (ok && (nib_q[2*i] != b[3:0] || nib_q[2*i+1] != b[7:4])) ok = 1'b0;
        end
        if (!ok) begin
            errors++;
            $display("FAIL burst_%0d: got %0d nibbles, required %0d nibbles of a %0d-byte frame (or data differs)",
                     burst_no, nib_q.size(), 2 * n, n);
        end
        frames_out++;
        bytes_out += n;
        nib_q.delete();
    endtask

    // Samples outputs on the falling edge; disabled in bypass mode and while the link is down.
    task automatic mon_sample();
        if (tx_overflow === 1'b1) ovf_cnt++;
        if (!link || !mon_en) begin
            nib_q.delete();
            in_burst = 1'b0;
            idle_cnt = 1000;
            return;
        end
        if (gmii_tx_en === 1'b1) begin
            if (!in_burst) begin
                in_burst = 1'b1;
                check("ifg_gap_min24", 32'(idle_cnt >= IFG), 32'd1);
            end
            if (gmii_txd[7:4] != 4'h0) check("txd_upper_zero", 32'(gmii_txd[7:4]), 32'd0);
            nib_q.push_back(gmii_txd[3:0]);
        end else begin
            if (in_burst) begin
                check("txd_idle_zero", 32'(gmii_txd), 32'd0);
                end_burst();
                idle_cnt = 0;
            end
            in_burst = 1'b0;
            idle_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        mon_sample();
    endtask

    task automatic fill_rand(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(byte'($urandom_range(0, 255)));
    endtask

    task automatic send_frame(input int gap, input bit expect_ok);
        if (expect_ok) begin
            exp_lens.push_back(frm.size());
            foreach (frm[i]) exp_bytes.push_back(frm[i]);
            bytes_sent += frm.size();
            frames_sent++;
        end
        foreach (frm[i]) begin
            mac_tx_dv = 1'b1;
            mac_txd   = frm[i];
            tick();
        end
        mac_tx_dv = 1'b0;
        mac_txd   = 8'($urandom_range(0, 255));
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_lens.size() != 0 && k < 20000) begin
            tick();
            k++;
        end
        check(name, 32'(exp_lens.size()), 32'd0);
        repeat (40) tick();
    endtask

    initial begin
        int ovf0, fo0, k, n;
        tbl[0] = '{1'b1, 8'h11, 1'b1, 8'h11};
        tbl[1] = '{1'b1, 8'h22, 1'b1, 8'h22};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 8'h33};
        tbl[3] = '{1'b1, 8'h44, 1'b1, 8'h44};
        tbl[4] = '{1'b1, 8'h55, 1'b1, 8'h55};
        tbl[5] = '{1'b0, 8'hAA, 1'b0, 8'hAA};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00};
        tbl[7] = '{1'b1, 8'hF0, 1'b1, 8'hF0};
        tbl[8] = '{1'b0, 8'h0F, 1'b0, 8'h0F};
        lat_nib = '{4'h2, 4'h1, 4'h4, 4'h3, 4'h6, 4'h5, 4'h8, 4'h7};

        // Reset, then link down: everything quiet
        repeat (3) tick();
        check("rst_tx_en", 32'(gmii_tx_en), 32'd0);
        check("rst_txd", 32'(gmii_txd), 32'd0);
        check("rst_overflow", 32'(tx_overflow), 32'd0);
        rst_n = 1'b1;
        mac_tx_dv = 1'b1;
        mac_txd = 8'h5A;
        tick();
        check("linkdown_tx_en", 32'(gmii_tx_en), 32'd0);
        check("linkdown_txd", 32'(gmii_txd), 32'd0);
        mac_tx_dv = 1'b0;

        // 1000M bypass: one register stage
        link = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            mac_tx_dv = tbl[i].dv;
            mac_txd   = tbl[i].d;
            tick();
            check($sformatf("bypass_en_%0d", i), 32'(gmii_tx_en), 32'(tbl[i].exp_en));
            check($sformatf("bypass_txd_%0d", i), 32'(gmii_txd), 32'(tbl[i].exp_d));
        end
        mac_tx_dv = 1'b0;
        repeat (3) tick();
        check("bypass_no_overflow", 32'(ovf_cnt), 32'd0);

        // Into 100M; nothing from the bypass traffic may be replayed
        link = 1'b0;
        tick();
        eth_100m_en = 1'b1;
        tick();
        link = 1'b1;
        mon_en = 1'b1;
        repeat (40) tick();
        check("bypass_not_buffered", 32'(burst_no), 32'd0);

        // 4-byte frame: tx_en rises exactly at T+4, nibbles low first
        frm.delete();
        frm.push_back(8'h12); frm.push_back(8'h34); frm.push_back(8'h56); frm.push_back(8'h78);
        send_frame(0, 1'b1);
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("lat_quiet_T+%0d", i), 32'(gmii_tx_en), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("lat_en_T+%0d", i + 4), 32'(gmii_tx_en), 32'd1);
            check($sformatf("lat_txd_T+%0d", i + 4), 32'(gmii_txd), 32'(lat_nib[i]));
        end
        tick();
        check("lat_end_T+12", 32'(gmii_tx_en), 32'd0);
        wait_drain("drain_4byte");

        // Single-byte frame
        frm.delete();
        frm.push_back(8'hA5);
        send_frame(1, 1'b1);
        wait_drain("drain_1byte");

        // Two 60-byte frames, one idle cycle apart
        fill_rand(60);
        send_frame(1, 1'b1);
        fill_rand(60);
        send_frame(1, 1'b1);
        wait_drain("drain_b2b60");

        // Longest accepted frame is DEPTH-1; DEPTH bytes drops and the next frame survives
        ovf0 = ovf_cnt;
        fill_rand(DEPTH - 1);
        send_frame(1, 1'b1);
        wait_drain("drain_maxlen");
        check("maxlen_no_overflow", 32'(ovf_cnt - ovf0), 32'd0);
        fill_rand(DEPTH);
        send_frame(1, 1'b0);
        fill_rand(10);
        send_frame(1, 1'b1);
        wait_drain("drain_after_long");
        check("long_frame_overflow", 32'(ovf_cnt - ovf0), 32'd1);

        // 2-byte frames every 3 cycles: pops happen at T1+2 and T1+33 only, so frames 1..18
        // fit (16 pending after frame 18) and frame 19 meets a full length FIFO
        ovf0 = ovf_cnt;
        for (int i = 0; i < 19; i++) begin
            fill_rand(2);
            send_frame(1, i < 18);
        end
        wait_drain("drain_lenfull");
        check("lenfull_overflow", 32'(ovf_cnt - ovf0), 32'd1);

        // Link drop mid-replay of 100 bytes, switch to 10M, then a clean frame
        ovf0 = ovf_cnt;
        fill_rand(100);
        send_frame(1, 1'b1);
        repeat (60) tick();
        check("mid_replay_en", 32'(gmii_tx_en), 32'd1);
        link = 1'b0;
        tick();
        check("flush_tx_en", 32'(gmii_tx_en), 32'd0);
        check("flush_txd", 32'(gmii_txd), 32'd0);
        exp_lens.delete();
        exp_bytes.delete();
        bytes_sent = bytes_out;
        frames_sent = frames_out;
        eth_100m_en = 1'b0;
        eth_10m_en = 1'b1;
        repeat (3) tick();
        link = 1'b1;
        repeat (40) tick();
        fo0 = frames_out;
        fill_rand(3);
        send_frame(1, 1'b1);
        wait_drain("drain_after_flush");
        check("after_flush_frames", 32'(frames_out - fo0), 32'd1);
        check("flush_no_overflow", 32'(ovf_cnt - ovf0), 32'd0);

        // Random frames, paced so the reference never expects a drop
        ovf0 = ovf_cnt;
        fo0 = frames_out;
        for (int f = 0; f < 30; f++) begin
            n = $urandom_range(1, 40);
            k = 0;
            while (!((bytes_sent - bytes_out + n <= DEPTH - 1) && (frames_sent - frames_out < LDEPTH))
                   && k < 5000) begin
                tick();
                k++;
            end
            if (k >= 5000) check("rand_pacing_timeout", 32'(k), 32'd0);
            fill_rand(n);
            send_frame($urandom_range(1, 20), 1'b1);
        end
        wait_drain("drain_random");
        check("random_frames", 32'(frames_out - fo0), 32'd30);
        check("random_no_overflow", 32'(ovf_cnt - ovf0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
